// File: rtl/mips_imem_responder_if.sv
//------------------------------------------------------------------------------
// mips_imem_responder_if
//
// Purpose:
//    Bundles the fetch handshake, the flush input and the memory load port
//    of the IF-stage instruction-memory responder.
//
// Parameters:
//    DEPTH_LOG2 - log2 of the number of 32-bit words. This must match the
//                 responder instance it connects to.
//
// Signals:
//    req_valid  (master->slave)  IF stage presents a fetch address
//    req_ready  (slave->master)  responder can accept a request this cycle
//    req_addr   (master->slave)  32-bit byte address (PC)
//    resp_valid (slave->master)  one-cycle pulse, resp_instr is valid
//    resp_instr (slave->master)  fetched instruction
//    resp_err   (slave->master)  error flag for the response (IMEM_ERR_EN only)
//    flush      (master->slave)  cancel any outstanding fetch (branch taken)
//    load_we    (master->slave)  load-port write enable
//    load_addr  (master->slave)  load-port word index
//    load_data  (master->slave)  load-port write data
//
// Configuration macro: IMEM_ERR_EN adds the resp_err signal.
//------------------------------------------------------------------------------
interface mips_imem_responder_if #(
   parameter int DEPTH_LOG2 = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_addr;
   logic                  resp_valid;
   logic [31:0]           resp_instr;
`ifdef IMEM_ERR_EN
   logic                  resp_err;
`endif
   logic                  flush;
   logic                  load_we;
   logic [DEPTH_LOG2-1:0] load_addr;
   logic [31:0]           load_data;

`ifdef IMEM_ERR_EN
   modport master (
      output req_valid, req_addr, flush, load_we, load_addr, load_data,
      input  req_ready, resp_valid, resp_instr, resp_err
   );
   modport slave (
      input  req_valid, req_addr, flush, load_we, load_addr, load_data,
      output req_ready, resp_valid, resp_instr, resp_err
   );
`else
   modport master (
      output req_valid, req_addr, flush, load_we, load_addr, load_data,
      input  req_ready, resp_valid, resp_instr
   );
   modport slave (
      input  req_valid, req_addr, flush, load_we, load_addr, load_data,
      output req_ready, resp_valid, resp_instr
   );
`endif
endinterface : mips_imem_responder_if

// File: rtl/mips_imem_responder.sv
//------------------------------------------------------------------------------
// mips_imem_responder
//
// Purpose:
//    Instruction-memory responder for the IF stage of the MIPS pipeline.
//    It accepts one fetch at a time over a valid/ready handshake. It samples
//    the addressed word at the accept edge and raises resp_valid for one
//    cycle, exactly LATENCY cycles after that edge. A flush drops an in-flight
//    fetch. A load port writes the word array at any time.
//
// Parameters:
//    DEPTH_LOG2 - log2 of the number of 32-bit words (default 256 words)
//    LATENCY    - cycles from the accept edge to resp_valid high (1..15)
//    NOP_WORD   - instruction returned for erroneous fetches
//
// Ports:
//    clk  - system clock, all state changes on the rising edge
//    rst  - synchronous, active-high reset (the memory array is not cleared)
//    bus  - mips_imem_responder_if.slave: req/resp handshake, flush, load port
//
// Configuration macro: IMEM_ERR_EN
//    Defined  : a misaligned request (req_addr[1:0] != 0) or an out-of-range
//               request (address bits above the array set) completes with
//               normal timing, returns NOP_WORD and raises resp_err.
//    Undefined: no checks. The low two bits and the upper address bits are
//               ignored, so the address wraps modulo the depth.
//------------------------------------------------------------------------------
module mips_imem_responder #(
   parameter int          DEPTH_LOG2 = 8,
   parameter int          LATENCY    = 2,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input logic                   clk,
   input logic                   rst,
   mips_imem_responder_if.slave  bus
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   // The counter is preloaded with LATENCY-1. BUSY leaves when the counter
   // would reach zero, so RESP follows the accept edge after LATENCY edges.
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           data_q, data_d;
   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_instr_q, resp_instr_d;

   logic [31:0]           mem_q [DEPTH];

   logic                  accept_s;
   logic [DEPTH_LOG2-1:0] idx_s;
   logic [31:0]           fetch_word_s;

`ifdef IMEM_ERR_EN
   logic                  req_bad_s;
   logic                  err_q, err_d;
   logic                  resp_err_q, resp_err_d;
`else
   // Address bits that play no part in the wrapping index.
   logic [31-DEPTH_LOG2:0] addr_unused_s;
`endif

   // Word array: load-port writes, no reset (contents survive rst)
   always_ff @(posedge clk) begin
      if (bus.load_we) begin
         mem_q[bus.load_addr] <= bus.load_data;
      end
   end

   // Request decode: acceptance, word index and the word sampled at the accept edge
   always_comb begin
      accept_s = bus.req_valid & req_ready_q;
      idx_s    = bus.req_addr[DEPTH_LOG2+1:2];
`ifdef IMEM_ERR_EN
      req_bad_s = (bus.req_addr[1:0] != 2'b00) ||
                  ((bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
      if (req_bad_s) begin
         fetch_word_s = NOP_WORD;
      end else begin
         fetch_word_s = mem_q[idx_s];
      end
`else
      addr_unused_s = {bus.req_addr[31:DEPTH_LOG2+2], bus.req_addr[1:0]};
      // The array read sees the value from before any same-edge load write,
      // so a colliding load returns the old word.
      fetch_word_s  = mem_q[idx_s];
`endif
   end

   // FSM next state, latency counter, captured data and next registered outputs
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      resp_valid_d = 1'b0;
      resp_instr_d = resp_instr_q;
`ifdef IMEM_ERR_EN
      err_d        = err_q;
      resp_err_d   = 1'b0;
`endif

      case (state_q)
         // IDLE and RESP accept. A request accepted alongside flush starts the new fetch.
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               data_d = fetch_word_s;
               cnt_d  = CNT_LOAD;
`ifdef IMEM_ERR_EN
               err_d  = req_bad_s;
`endif
               if (CNT_LOAD == 4'd0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_BUSY;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         // Count down. Flush outranks the counter and drops the fetch.
         ST_BUSY: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               data_d  = NOP_WORD;
`ifdef IMEM_ERR_EN
               err_d   = 1'b0;
`endif
            end else if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               state_d = ST_BUSY;
               cnt_d   = cnt_q - 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // Enter RESP: when LATENCY is 1 the word comes straight from this edge's
      // sample, otherwise it comes from the data register.
      if (state_d == ST_RESP) begin
         resp_valid_d = 1'b1;
         if (accept_s) begin
            resp_instr_d = fetch_word_s;
`ifdef IMEM_ERR_EN
            resp_err_d   = req_bad_s;
`endif
         end else begin
            resp_instr_d = data_q;
`ifdef IMEM_ERR_EN
            resp_err_d   = err_q;
`endif
         end
      end else begin
         resp_valid_d = 1'b0;
      end

      req_ready_d = (state_d != ST_BUSY);
   end

   // State and output registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         data_q       <= NOP_WORD;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_instr_q <= 32'd0;
`ifdef IMEM_ERR_EN
         err_q        <= 1'b0;
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_instr_q <= resp_instr_d;
`ifdef IMEM_ERR_EN
         err_q        <= err_d;
         resp_err_q   <= resp_err_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_instr = resp_instr_q;
`ifdef IMEM_ERR_EN
   assign bus.resp_err   = resp_err_q;
`endif

endmodule : mips_imem_responder

// File: tb/tb_mips_imem_responder.sv
//------------------------------------------------------------------------------
// tb_mips_imem_responder
//
// Directed bench with three responder instances: LATENCY 2, 1 and 3.
// Outputs are sampled 1 time unit after a rising edge. The value sampled
// after edge k is the value seen at edge k+1, so a response "at edge A+L"
// appears L-1 steps after the accept step.
// Configuration macro: IMEM_ERR_EN selects the error test in place of the
// wrap test.
//------------------------------------------------------------------------------
module tb_mips_imem_responder;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mips_imem_responder_if #(.DEPTH_LOG2(8)) if_l2 ();
   mips_imem_responder_if #(.DEPTH_LOG2(8)) if_l1 ();
   mips_imem_responder_if #(.DEPTH_LOG2(8)) if_l3 ();

   mips_imem_responder #(.DEPTH_LOG2(8), .LATENCY(2), .NOP_WORD(32'h0000_0000)) u_l2 (
      .clk(clk), .rst(rst), .bus(if_l2));
   mips_imem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .NOP_WORD(32'h0000_0000)) u_l1 (
      .clk(clk), .rst(rst), .bus(if_l1));
   mips_imem_responder #(.DEPTH_LOG2(8), .LATENCY(3), .NOP_WORD(32'h0000_0000)) u_l3 (
      .clk(clk), .rst(rst), .bus(if_l3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Writes one word through the load port of all three instances.
   task automatic load_all(input logic [7:0] idx, input logic [31:0] data);
      if_l2.load_we = 1'b1; if_l2.load_addr = idx; if_l2.load_data = data;
      if_l1.load_we = 1'b1; if_l1.load_addr = idx; if_l1.load_data = data;
      if_l3.load_we = 1'b1; if_l3.load_addr = idx; if_l3.load_data = data;
      step();
      if_l2.load_we = 1'b0;
      if_l1.load_we = 1'b0;
      if_l3.load_we = 1'b0;
   endtask

   // Presents one request to the LATENCY=2 instance and waits (bounded) for
   // the response. lat is the number of steps after the accept step, or -1.
   task automatic fetch_l2(input logic [31:0] addr, output int lat,
                           output logic [31:0] instr, output logic err);
      lat   = -1;
      instr = 32'd0;
      err   = 1'b0;
      if_l2.req_valid = 1'b1;
      if_l2.req_addr  = addr;
      step();
      if_l2.req_valid = 1'b0;
      for (int n = 0; n < 16 && lat < 0; n++) begin
         if (if_l2.resp_valid === 1'b1) begin
            lat   = n;
            instr = if_l2.resp_instr;
`ifdef IMEM_ERR_EN
            err   = if_l2.resp_err;
`endif
         end else begin
            step();
         end
      end
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (if_l2.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_l2 got=%b exp=1", if_l2.req_ready); end
      checks++; if (if_l2.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_l2 got=%b exp=0", if_l2.resp_valid); end
      checks++; if (if_l2.resp_instr !== 32'h0) begin failures++; $display("FAIL reset_instr_l2 got=%h exp=00000000", if_l2.resp_instr); end
      checks++; if (if_l1.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_l1 got=%b exp=1", if_l1.req_ready); end
      checks++; if (if_l1.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_l1 got=%b exp=0", if_l1.resp_valid); end
      checks++; if (if_l3.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid_l3 got=%b exp=0", if_l3.resp_valid); end
`ifdef IMEM_ERR_EN
      checks++; if (if_l2.resp_err !== 1'b0) begin failures++; $display("FAIL reset_err_l2 got=%b exp=0", if_l2.resp_err); end
`endif
   endtask

   // LATENCY=2: the accept edge gives BUSY, the next edge gives RESP, the edge after that gives IDLE.
   task automatic test_latency2();
      if_l2.req_valid = 1'b1;
      if_l2.req_addr  = 32'h0;
      step();
      if_l2.req_valid = 1'b0;
      checks++; if (if_l2.req_ready !== 1'b0) begin failures++; $display("FAIL lat2_busy_ready got=%b exp=0", if_l2.req_ready); end
      checks++; if (if_l2.resp_valid !== 1'b0) begin failures++; $display("FAIL lat2_early_valid got=%b exp=0", if_l2.resp_valid); end
      step();
      checks++; if (if_l2.resp_valid !== 1'b1) begin failures++; $display("FAIL lat2_valid got=%b exp=1", if_l2.resp_valid); end
      checks++; if (if_l2.resp_instr !== 32'h2008_0005) begin failures++; $display("FAIL lat2_instr got=%h exp=20080005", if_l2.resp_instr); end
      checks++; if (if_l2.req_ready !== 1'b1) begin failures++; $display("FAIL lat2_resp_ready got=%b exp=1", if_l2.req_ready); end
      step();
      checks++; if (if_l2.resp_valid !== 1'b0) begin failures++; $display("FAIL lat2_pulse got=%b exp=0", if_l2.resp_valid); end
      checks++; if (if_l2.resp_instr !== 32'h2008_0005) begin failures++; $display("FAIL lat2_hold got=%h exp=20080005", if_l2.resp_instr); end
   endtask

   // LATENCY=1: a request held for two edges yields two consecutive responses.
   task automatic test_back_to_back();
      if_l1.req_valid = 1'b1;
      if_l1.req_addr  = 32'h0;
      step();
      checks++; if (if_l1.resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid0 got=%b exp=1", if_l1.resp_valid); end
      checks++; if (if_l1.resp_instr !== 32'h2008_0005) begin failures++; $display("FAIL b2b_instr0 got=%h exp=20080005", if_l1.resp_instr); end
      if_l1.req_addr = 32'h4;
      step();
      if_l1.req_valid = 1'b0;
      checks++; if (if_l1.resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", if_l1.resp_valid); end
      checks++; if (if_l1.resp_instr !== 32'h8C09_0004) begin failures++; $display("FAIL b2b_instr1 got=%h exp=8c090004", if_l1.resp_instr); end
      step();
      checks++; if (if_l1.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", if_l1.resp_valid); end
   endtask

   // LATENCY=3: flush one cycle after accept discards the fetch.
   task automatic test_flush();
      logic seen;
      int   lat;
      if_l3.req_valid = 1'b1;
      if_l3.req_addr  = 32'h4;
      step();
      if_l3.req_valid = 1'b0;
      if_l3.flush     = 1'b1;
      step();
      if_l3.flush = 1'b0;
      checks++; if (if_l3.req_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", if_l3.req_ready); end
      seen = 1'b0;
      for (int n = 0; n < 5; n++) begin
         if (if_l3.resp_valid !== 1'b0) seen = 1'b1;
         step();
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_resp got=%b exp=0", seen); end
      if_l3.req_valid = 1'b1;
      if_l3.req_addr  = 32'h0;
      step();
      if_l3.req_valid = 1'b0;
      lat = -1;
      for (int n = 0; n < 12 && lat < 0; n++) begin
         if (if_l3.resp_valid === 1'b1) lat = n;
         else step();
      end
      // The response at edge A+3 appears 2 steps after the accept step.
      checks++; if (lat != 2) begin failures++; $display("FAIL flush_refetch_lat got=%0d exp=2", lat); end
      checks++; if (if_l3.resp_instr !== 32'h2008_0005) begin failures++; $display("FAIL flush_refetch_instr got=%h exp=20080005", if_l3.resp_instr); end
      step();
   endtask

   // Reset during BUSY drops the fetch and clears resp_instr.
   task automatic test_reset_busy();
      logic seen;
      if_l2.req_valid = 1'b1;
      if_l2.req_addr  = 32'h4;
      step();
      if_l2.req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (if_l2.resp_valid !== 1'b0) begin failures++; $display("FAIL rstbusy_valid got=%b exp=0", if_l2.resp_valid); end
      checks++; if (if_l2.resp_instr !== 32'h0) begin failures++; $display("FAIL rstbusy_instr got=%h exp=00000000", if_l2.resp_instr); end
      checks++; if (if_l2.req_ready !== 1'b1) begin failures++; $display("FAIL rstbusy_ready got=%b exp=1", if_l2.req_ready); end
      seen = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (if_l2.resp_valid !== 1'b0) seen = 1'b1;
         step();
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstbusy_no_resp got=%b exp=0", seen); end
   endtask

   // Load collisions: a same-edge write returns the old word, and a later write does not disturb an accepted fetch.
   task automatic test_load_collision();
      int          lat;
      logic [31:0] instr;
      logic        err;
      if_l2.req_valid = 1'b1;
      if_l2.req_addr  = 32'h4;
      if_l2.load_we   = 1'b1;
      if_l2.load_addr = 8'd1;
      if_l2.load_data = 32'hFFFF_FFFF;
      step();
      if_l2.req_valid = 1'b0;
      if_l2.load_we   = 1'b0;
      step();
      checks++; if (if_l2.resp_instr !== 32'h8C09_0004) begin failures++; $display("FAIL collide_old got=%h exp=8c090004", if_l2.resp_instr); end
      step();
      fetch_l2(32'h4, lat, instr, err);
      checks++; if (lat != 1) begin failures++; $display("FAIL collide_new_lat got=%0d exp=1", lat); end
      checks++; if (instr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL collide_new got=%h exp=ffffffff", instr); end
      if_l2.req_valid = 1'b1;
      if_l2.req_addr  = 32'h0;
      step();
      if_l2.req_valid = 1'b0;
      if_l2.load_we   = 1'b1;
      if_l2.load_addr = 8'd0;
      if_l2.load_data = 32'h1111_1111;
      step();
      if_l2.load_we = 1'b0;
      checks++; if (if_l2.resp_instr !== 32'h2008_0005) begin failures++; $display("FAIL late_write got=%h exp=20080005", if_l2.resp_instr); end
      step();
   endtask

`ifdef IMEM_ERR_EN
   task automatic test_err();
      int          lat;
      logic [31:0] instr;
      logic        err;
      load_all(8'hFF, 32'h1234_5678);
      fetch_l2(32'h402, lat, instr, err);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_misalign got=%b exp=1", err); end
      checks++; if (instr !== 32'h0) begin failures++; $display("FAIL err_misalign_instr got=%h exp=00000000", instr); end
      checks++; if (lat != 1) begin failures++; $display("FAIL err_misalign_lat got=%0d exp=1", lat); end
      fetch_l2(32'h400, lat, instr, err);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_range got=%b exp=1", err); end
      fetch_l2(32'h3FC, lat, instr, err);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_ok got=%b exp=0", err); end
      checks++; if (instr !== 32'h1234_5678) begin failures++; $display("FAIL err_ok_instr got=%h exp=12345678", instr); end
      checks++; if (if_l2.resp_err !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", if_l2.resp_err); end
   endtask
`else
   // 0x407 wraps to word index 1 (low bits and bit 10 ignored).
   task automatic test_wrap();
      int          lat;
      logic [31:0] instr;
      logic        err;
      fetch_l2(32'h407, lat, instr, err);
      checks++; if (lat != 1) begin failures++; $display("FAIL wrap_lat got=%0d exp=1", lat); end
      checks++; if (instr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_instr got=%h exp=ffffffff", instr); end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      if_l2.req_valid = 1'b0; if_l2.req_addr = 32'h0; if_l2.flush = 1'b0;
      if_l2.load_we = 1'b0; if_l2.load_addr = 8'd0; if_l2.load_data = 32'h0;
      if_l1.req_valid = 1'b0; if_l1.req_addr = 32'h0; if_l1.flush = 1'b0;
      if_l1.load_we = 1'b0; if_l1.load_addr = 8'd0; if_l1.load_data = 32'h0;
      if_l3.req_valid = 1'b0; if_l3.req_addr = 32'h0; if_l3.flush = 1'b0;
      if_l3.load_we = 1'b0; if_l3.load_addr = 8'd0; if_l3.load_data = 32'h0;

      test_reset();
      load_all(8'd0, 32'h2008_0005);
      load_all(8'd1, 32'h8C09_0004);
      test_latency2();
      test_back_to_back();
      test_flush();
      test_reset_busy();
      test_load_collision();
`ifdef IMEM_ERR_EN
      test_err();
`else
      test_wrap();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mips_imem_responder
